// File: rtl/ulx3s_reset_ce_sequencer.sv
// ulx3s_reset_ce_sequencer: lock-qualified staggered reset release and
// per-domain clock-enable strobes, all in the PLL output clock domain.
//
// Ports:
//   clock           PLL output clock (only clock)
//   resetn          synchronous active-low reset
//   pll_locked      raw PLL LOCK, asynchronous to clock
//   rst_out_n[NCH]  per-domain active-low resets, released in order 0..NCH-1
//   ce[NCH]         per-domain clock-enable strobes, one pulse every DIVS[i]
//   ready           all channels released
//   lock_loss_count saturating count of lock losses after release began

module ulx3s_reset_ce_sequencer #(
  parameter int                   NCH         = 4,
  parameter int                   DIVW        = 8,
  parameter logic [NCH*DIVW-1:0]  DIVS        = {8'd8, 8'd4, 8'd2, 8'd1},
  parameter int                   LOCK_CYCLES = 1024,
  parameter int                   STAGGER     = 16,
  parameter int                   LOSSW       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pll_locked,
  output logic [NCH-1:0]   rst_out_n,
  output logic [NCH-1:0]   ce,
  output logic             ready,
  output logic [LOSSW-1:0] lock_loss_count
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] LC_LAST  = CW'(LOCK_CYCLES - 1);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGGER - 1);
  localparam logic [IW-1:0] CH_LAST  = IW'(NCH - 1);
  localparam logic [IW-1:0] CH_ONE   = IW'(1);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_STABLE = 2'd1;
  localparam logic [1:0] S_REL    = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  // synchroniser
  logic             r_sync1;
  logic             r_lk_s;

  // sequencer state
  logic [1:0]       r_state;
  logic [CW-1:0]    r_scnt;
  logic [SW-1:0]    r_stg;
  logic [IW-1:0]    r_ch;
  logic [NCH-1:0]   r_rst;
  logic             r_ready;
  logic [LOSSW-1:0] r_loss;

  // clock-enable dividers
  logic [DIVW-1:0]  r_dc [NCH];
  logic [NCH-1:0]   r_ce;

  // next-state
  logic [1:0]       w_state_n;
  logic [CW-1:0]    w_scnt_n;
  logic [SW-1:0]    w_stg_n;
  logic [IW-1:0]    w_ch_n;
  logic [NCH-1:0]   w_rel_n;
  logic             w_ready_n;
  logic [LOSSW-1:0] w_loss_n;
  logic             w_lost;

  // divisor minus one per channel; a zero divisor behaves as one
  logic [DIVW-1:0]  w_dm1 [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_div
    localparam logic [DIVW-1:0] D = DIVS[g*DIVW +: DIVW];
    assign w_dm1[g] = (D == '0) ? '0 : D - 1'b1;
  end

  assign w_lost = !r_lk_s && (r_state == S_REL || r_state == S_RUN);

  always_comb begin
    w_state_n = r_state;
    w_scnt_n  = r_scnt;
    w_stg_n   = r_stg;
    w_ch_n    = r_ch;
    w_rel_n   = r_rst;
    w_ready_n = r_ready;
    w_loss_n  = r_loss;
    if (w_lost) begin
      // lock dropped after release started: pull everything down
      w_state_n = S_WAIT;
      w_scnt_n  = '0;
      w_stg_n   = '0;
      w_ch_n    = '0;
      w_rel_n   = '0;
      w_ready_n = 1'b0;
      w_loss_n  = (&r_loss) ? r_loss : r_loss + 1'b1;
    end else begin
      unique case (1'b1)
        (r_state == S_WAIT): begin
          w_scnt_n = '0;
          if (r_lk_s) begin
            w_state_n = S_STABLE;
            w_scnt_n  = CW'(1);
          end
        end
        (r_state == S_STABLE): begin
          if (!r_lk_s) begin
            w_state_n = S_WAIT;
            w_scnt_n  = '0;
          end else if (r_scnt == LC_LAST) begin
            // this cycle is the LOCK_CYCLES-th consecutive high sample
            w_scnt_n   = '0;
            w_stg_n    = '0;
            w_rel_n[0] = 1'b1;
            if (NCH == 1) begin
              w_state_n = S_RUN;
              w_ready_n = 1'b1;
            end else begin
              w_state_n = S_REL;
              w_ch_n    = CH_ONE;
            end
          end else begin
            w_scnt_n = r_scnt + 1'b1;
          end
        end
        (r_state == S_REL): begin
          if (r_stg == STG_LAST) begin
            w_stg_n       = '0;
            w_rel_n[r_ch] = 1'b1;
            if (r_ch == CH_LAST) begin
              w_state_n = S_RUN;
              w_ready_n = 1'b1;
            end else begin
              w_ch_n = r_ch + 1'b1;
            end
          end else begin
            w_stg_n = r_stg + 1'b1;
          end
        end
        (r_state == S_RUN): begin
          w_rel_n   = '1;
          w_ready_n = 1'b1;
        end
        default: begin
          w_state_n = S_WAIT;
          w_scnt_n  = '0;
          w_stg_n   = '0;
          w_ch_n    = '0;
          w_rel_n   = '0;
          w_ready_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_lk_s  <= 1'b0;
      r_state <= S_WAIT;
      r_scnt  <= '0;
      r_stg   <= '0;
      r_ch    <= '0;
      r_rst   <= '0;
      r_ready <= 1'b0;
      r_loss  <= '0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk_s  <= r_sync1;
      r_state <= w_state_n;
      r_scnt  <= w_scnt_n;
      r_stg   <= w_stg_n;
      r_ch    <= w_ch_n;
      r_rst   <= w_rel_n;
      r_ready <= w_ready_n;
      r_loss  <= w_loss_n;
    end
  end

  // A divider runs only while its channel was released last cycle and
  // stays released this cycle, so a loss kills the strobe immediately
  // and the counter restarts from 0 on the next release.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        r_dc[i] <= '0;
      end
      r_ce <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_rst[i] && w_rel_n[i]) begin
          r_ce[i] <= (r_dc[i] == w_dm1[i]);
          r_dc[i] <= (r_dc[i] == w_dm1[i]) ? '0 : r_dc[i] + 1'b1;
        end else begin
          r_ce[i] <= 1'b0;
          r_dc[i] <= '0;
        end
      end
    end
  end

  assign rst_out_n       = r_rst;
  assign ce              = r_ce;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss;

endmodule

// File: tb/tb_ulx3s_reset_ce_sequencer.sv
// tb_ulx3s_reset_ce_sequencer: directed and random lock patterns against a
// timing-rule reference model (NCH=3, DIVS={3,2,1}, LOCK_CYCLES=8, STAGGER=4).

module tb_ulx3s_reset_ce_sequencer;

  localparam int NCH   = 3;
  localparam int DIVW  = 8;
  localparam int LC    = 8;
  localparam int ST    = 4;
  localparam int LOSSW = 2;
  localparam logic [NCH*DIVW-1:0] DIVS = {8'd3, 8'd2, 8'd1};
  localparam int HMAX  = 16384;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             pll_locked = 1'b1;
  logic [NCH-1:0]   rst_out_n;
  logic [NCH-1:0]   ce;
  logic             ready;
  logic [LOSSW-1:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

  ulx3s_reset_ce_sequencer #(
    .NCH(NCH), .DIVW(DIVW), .DIVS(DIVS),
    .LOCK_CYCLES(LC), .STAGGER(ST), .LOSSW(LOSSW)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .pll_locked(pll_locked),
    .rst_out_n(rst_out_n),
    .ce(ce),
    .ready(ready),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  // Reference model. Edge n samples pll_locked into h_lk[n]; the sequencer
  // acts on that sample two edges later unless a reset intervened. Release
  // happens on the LC-th consecutive acted-on high sample; afterwards the
  // outputs are pure functions of the edge distance from that release.
  bit h_lk [HMAX];
  bit h_rs [HMAX];
  int dv [NCH] = '{1, 2, 3};
  int m_n    = 0;
  bit m_rel  = 0;
  int m_trel = 0;
  int m_run  = 0;
  int m_loss = 0;

  function automatic logic [NCH-1:0] e_rst();
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      r[i] = m_rel && (m_n - m_trel >= i * ST);
    return r;
  endfunction

  function automatic logic [NCH-1:0] e_ce();
    logic [NCH-1:0] r;
    int t;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      t = m_trel + i * ST;
      r[i] = m_rel && (m_n > t) && ((m_n - t) % dv[i] == 0);
    end
    return r;
  endfunction

  task automatic model_step();
    bit seen;
    m_n++;
    h_lk[m_n] = pll_locked;
    h_rs[m_n] = !resetn;
    if (h_rs[m_n]) begin
      m_rel  = 0;
      m_run  = 0;
      m_loss = 0;
    end else begin
      seen = (m_n >= 3) && h_lk[m_n-2] && !h_rs[m_n-1] && !h_rs[m_n-2];
      if (m_rel) begin
        if (!seen) begin
          m_rel  = 0;
          m_run  = 0;
          m_loss = (m_loss < 3) ? m_loss + 1 : 3;
        end
      end else begin
        m_run = seen ? m_run + 1 : 0;
        if (m_run == LC) begin
          m_rel  = 1;
          m_trel = m_n;
          m_run  = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge %0d: got %0h want %0h", tag, m_n, obs, exp);
    end
  endtask

  // one clock: model follows the edge, DUT checked on the falling edge
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("rst_out_n", 32'(rst_out_n), 32'(e_rst()));
    chk("ce", 32'(ce), 32'(e_ce()));
    chk("ready", 32'(ready), 32'(m_rel && (m_n - m_trel >= (NCH-1)*ST)));
    chk("loss_cnt", 32'(lock_loss_count), 32'(m_loss));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int seg;

    // reset held 3 edges with lock already high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_all0", 32'({rst_out_n, ce, ready, lock_loss_count}), 32'd0);
    end
    resetn     = 1'b1;
    pll_locked = 1'b0;
    ticks(6);

    // clean lock, first sampled at edge 10
    pll_locked = 1'b1;
    while (m_n < 32) begin
      tick();
      case (m_n)
        18: chk("pre_rel0", 32'(rst_out_n), 32'b000);
        19: begin
          chk("rel0", 32'(rst_out_n), 32'b001);
          chk("ce0_off", 32'(ce[0]), 32'd0);
        end
        20: chk("ce0_first", 32'(ce[0]), 32'd1);
        22: chk("pre_rel1", 32'(rst_out_n), 32'b001);
        23: chk("rel1", 32'(rst_out_n), 32'b011);
        24: chk("ce1_off", 32'(ce[1]), 32'd0);
        25: chk("ce1_first", 32'(ce[1]), 32'd1);
        26: chk("pre_ready", 32'(ready), 32'd0);
        27: begin
          chk("rel2", 32'(rst_out_n), 32'b111);
          chk("ready_up", 32'(ready), 32'd1);
          chk("ce1_second", 32'(ce[1]), 32'd1);
        end
        29: chk("ce2_off", 32'(ce[2]), 32'd0);
        30: chk("ce2_first", 32'(ce[2]), 32'd1);
        default: ;
      endcase
    end

    // loss in RUN: outputs drop on the third edge after the drive
    pll_locked = 1'b0;
    ticks(2);
    chk("loss_lat_ready", 32'(ready), 32'd1);
    tick();
    chk("loss_rst", 32'(rst_out_n), 32'b000);
    chk("loss_ce", 32'(ce), 32'b000);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_cnt1", 32'(lock_loss_count), 32'd1);

    // lock returns with a 2-cycle glitch at stable count 5
    pll_locked = 1'b1;
    ticks(5);
    pll_locked = 1'b0;
    ticks(2);
    pll_locked = 1'b1;
    ticks(3);
    chk("glitch_norel", 32'(rst_out_n), 32'b000);
    chk("glitch_cnt", 32'(lock_loss_count), 32'd1);
    while (m_n < 51) tick();
    chk("glitch_wait", 32'(rst_out_n), 32'b000);
    tick();
    chk("glitch_rel0", 32'(rst_out_n), 32'b001);
    ticks(8);
    chk("relock_ready", 32'(ready), 32'd1);

    // three more losses in RUN: counter saturates at 3
    for (int k = 2; k <= 4; k++) begin
      pll_locked = 1'b0;
      ticks(3);
      chk("sat_cnt", 32'(lock_loss_count), 32'(k < 3 ? k : 3));
      pll_locked = 1'b1;
      ticks(20);
      chk("sat_ready", 32'(ready), 32'd1);
    end

    // reset in the middle of the release staircase
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    ticks(11);
    chk("mid_rel", 32'(rst_out_n), 32'b001);
    resetn = 1'b0;
    tick();
    chk("mid_rst_out", 32'({rst_out_n, ce, ready}), 32'd0);
    chk("mid_rst_cnt", 32'(lock_loss_count), 32'd0);
    ticks(2);
    resetn = 1'b1;
    ticks(9);
    chk("restart_wait", 32'(rst_out_n), 32'b000);
    tick();
    chk("restart_rel0", 32'(rst_out_n), 32'b001);
    ticks(10);
    chk("restart_ready", 32'(ready), 32'd1);

    // random lock/reset patterns
    for (int s = 0; s < 90; s++) begin
      if ($urandom_range(0, 11) == 0) begin
        resetn = 1'b0;
        ticks($urandom_range(1, 3));
        resetn = 1'b1;
      end
      pll_locked = ($urandom_range(0, 3) != 0);
      seg = pll_locked ? $urandom_range(1, 36) : $urandom_range(1, 5);
      ticks(seg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
